// File: rtl/serial_bcd_xs3_codec_pkg.sv
// ---------------------------------------------------------------------------
// serial_codec_pkg
// Shared types and constants for the bit-serial BCD <-> Excess-3 codec.
//   mode_e        : conversion direction (BCD->XS3 adds 3, XS3->BCD subtracts 3)
//   K_ADD3/K_SUB3 : per-digit addend; subtracting 3 is adding 13 mod 16
//   BCD_MAX, XS3_MIN, XS3_MAX : legal digit ranges for the invalid-digit check
// Optional feature macro used by importers: SERIAL_CODEC_CHECK_EN
// ---------------------------------------------------------------------------
package serial_codec_pkg;

  typedef enum logic {
    MODE_BCD2XS3 = 1'b0,
    MODE_XS32BCD = 1'b1
  } mode_e;

  localparam logic [3:0] K_ADD3  = 4'b0011;
  localparam logic [3:0] K_SUB3  = 4'b1101;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;

  // Addend nibble for the selected direction.
  function automatic logic [3:0] mode_k(input mode_e m);
    return (m == MODE_XS32BCD) ? K_SUB3 : K_ADD3;
  endfunction

  // True when a completed input digit is outside the legal code range.
  function automatic logic digit_invalid(input mode_e m, input logic [3:0] d);
    if (m == MODE_BCD2XS3)
      return (d > BCD_MAX);
    else
      return (d < XS3_MIN) || (d > XS3_MAX);
  endfunction

endpackage

// File: rtl/serial_bcd_xs3_codec_if.sv
// ---------------------------------------------------------------------------
// serial_bcd_xs3_codec_if
// Stream bundle for the serial codec.
//   master : drives mode, x, in_valid; observes z, out_valid, digit_last,
//            frame_last, err
//   slave  : the codec side (mirror directions)
// ---------------------------------------------------------------------------
interface serial_bcd_xs3_codec_if;
  logic mode;
  logic x;
  logic in_valid;
  logic z;
  logic out_valid;
  logic digit_last;
  logic frame_last;
  logic err;

  modport master (
    output mode, x, in_valid,
    input  z, out_valid, digit_last, frame_last, err
  );

  modport slave (
    input  mode, x, in_valid,
    output z, out_valid, digit_last, frame_last, err
  );
endinterface

// File: rtl/serial_bcd_xs3_codec_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
// One-bit serial full adder with a carry flop. The carry is ignored at the
// first bit of every digit, so each nibble is added independently and the
// carry out of bit 3 never leaks into the next digit.
// Ports:
//   clock         : rising-edge clock
//   reset         : asynchronous active-low reset
//   i_en          : a bit is accepted this cycle (carry updates only then)
//   i_digit_start : current bit is bit 0 of a digit
//   i_a, i_b      : operand bits
//   o_sum         : combinational sum bit
// ---------------------------------------------------------------------------
module serial_nibble_adder (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_digit_start,
  input  logic i_a,
  input  logic i_b,
  output logic o_sum
);

  logic r_carry;
  logic w_cin;

  assign w_cin = i_digit_start ? 1'b0 : r_carry;
  assign o_sum = i_a ^ i_b ^ w_cin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= (i_a & i_b) | (i_a & w_cin) | (i_b & w_cin);
    end
  end

endmodule

// File: rtl/serial_bcd_xs3_codec.sv
// ---------------------------------------------------------------------------
// serial_bcd_xs3_codec
// Bit-serial, LSB-first BCD <-> Excess-3 converter for frames of DIGITS
// 4-bit digits. One bit is converted per accepted beat; results are
// registered (1-cycle latency) with digit/frame boundary strobes.
// Parameters:
//   DIGITS : digits per frame (1..16)
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of serial_bcd_xs3_codec_if
//            (mode, x, in_valid in; z, out_valid, digit_last, frame_last, err out)
// Optional feature: define SERIAL_CODEC_CHECK_EN to enable the invalid-digit
// check (err). Without it err is constant 0 and no digit capture exists.
// ---------------------------------------------------------------------------
module serial_bcd_xs3_codec
  import serial_codec_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  serial_bcd_xs3_codec_if.slave  bus
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  logic [1:0]    r_bit_idx;
  logic [CW-1:0] r_digit_cnt;
  mode_e         r_mode_q;

  logic r_z;
  logic r_out_valid;
  logic r_digit_last;
  logic r_frame_last;

  logic       w_frame_start;
  logic       w_bit_last;
  logic       w_cnt_last;
  mode_e      w_mode;
  logic [3:0] w_k;
  logic       w_sum;

  assign w_frame_start = (r_bit_idx == 2'd0) && (r_digit_cnt == '0);
  assign w_bit_last    = (r_bit_idx == 2'd3);
  assign w_cnt_last    = (r_digit_cnt == CNT_LAST);

  // The bit that latches the mode already converts with it, so the live
  // input is used instead of waiting for r_mode_q to update.
  assign w_mode = w_frame_start ? mode_e'(bus.mode) : r_mode_q;
  assign w_k    = mode_k(w_mode);

  serial_nibble_adder u_adder (
    .clock         (clock),
    .reset         (reset),
    .i_en          (bus.in_valid),
    .i_digit_start (r_bit_idx == 2'd0),
    .i_a           (bus.x),
    .i_b           (w_k[r_bit_idx]),
    .o_sum         (w_sum)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_idx    <= 2'd0;
      r_digit_cnt  <= '0;
      r_mode_q     <= MODE_BCD2XS3;
      r_z          <= 1'b0;
      r_out_valid  <= 1'b0;
      r_digit_last <= 1'b0;
      r_frame_last <= 1'b0;
    end else begin
      r_out_valid  <= bus.in_valid;
      r_digit_last <= bus.in_valid && w_bit_last;
      r_frame_last <= bus.in_valid && w_bit_last && w_cnt_last;
      if (bus.in_valid) begin
        r_z       <= w_sum;
        r_bit_idx <= r_bit_idx + 2'd1;   // natural 3 -> 0 wrap
        if (w_frame_start)
          r_mode_q <= w_mode;
        if (w_bit_last)
          r_digit_cnt <= w_cnt_last ? '0 : r_digit_cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_CODEC_CHECK_EN
  // Holds bits 0..2 of the current digit (bit 0 ends up in [0]); bit 3 is
  // taken live from x so the check covers the whole completed digit.
  logic [2:0] r_shift;
  logic       r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= bus.in_valid && w_bit_last && digit_invalid(w_mode, {bus.x, r_shift});
      if (bus.in_valid)
        r_shift <= {bus.x, r_shift[2:1]};
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.z          = r_z;
  assign bus.out_valid  = r_out_valid;
  assign bus.digit_last = r_digit_last;
  assign bus.frame_last = r_frame_last;

endmodule

// File: tb/tb_serial_bcd_xs3_codec.sv
// ---------------------------------------------------------------------------
// tb_serial_bcd_xs3_codec
// Drives the same serial stream into two codecs (DIGITS=1 and DIGITS=2).
// Expected bits are pushed to a scoreboard queue as each bit is driven and
// compared when the codecs report out_valid.
// ---------------------------------------------------------------------------
module tb_serial_bcd_xs3_codec;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serial_bcd_xs3_codec_if bus_a ();
  serial_bcd_xs3_codec_if bus_b ();

  serial_bcd_xs3_codec #(.DIGITS(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  serial_bcd_xs3_codec #(.DIGITS(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  // Index 0 -> dut_a, index 1 -> dut_b.
  typedef struct packed {
    logic [1:0] z;
    logic [1:0] dl;
    logic [1:0] fl;
    logic [1:0] er;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int ov_cnt_b = 0;
  int fl_cnt_b = 0;

  int   m_bidx [2];
  int   m_dcnt [2];
  int   m_cur  [2];
  logic m_mode [2];

  logic acc_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dg(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic bad_digit(input int d, input logic md);
    if (!md) return (d > 9);
    return (d < 3) || (d > 12);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bidx[i] = 0;
      m_dcnt[i] = 0;
      m_cur[i]  = 0;
      m_mode[i] = 1'b0;
    end
  endtask

  // Expected bit n of a digit is bit n of (partial digit + addend): lower
  // sum bits only depend on lower operand bits.
  task automatic push_bit(input logic b, input logic md);
    exp_t e;
    int   k;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_bidx[i] == 0 && m_dcnt[i] == 0) m_mode[i] = md;
      if (m_bidx[i] == 0) m_cur[i] = 0;
      m_cur[i] = m_cur[i] | (int'(b) << m_bidx[i]);
      k = m_mode[i] ? 13 : 3;
      e.z[i]  = 1'(((m_cur[i] + k) >> m_bidx[i]) & 1);
      e.dl[i] = (m_bidx[i] == 3);
      e.fl[i] = (m_bidx[i] == 3) && (m_dcnt[i] == dg(i) - 1);
`ifdef SERIAL_CODEC_CHECK_EN
      e.er[i] = (m_bidx[i] == 3) && bad_digit(m_cur[i], m_mode[i]);
`else
      e.er[i] = 1'b0;
`endif
      if (m_bidx[i] == 3) begin
        m_bidx[i] = 0;
        m_dcnt[i] = (m_dcnt[i] + 1) % dg(i);
      end else begin
        m_bidx[i] = m_bidx[i] + 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic b, input logic md, input logic v);
    bus_a.x = b;  bus_a.mode = md;  bus_a.in_valid = v;
    bus_b.x = b;  bus_b.mode = md;  bus_b.in_valid = v;
  endtask

  task automatic send(input logic b, input logic md, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
      drive(1'($urandom), ~md, 1'b0);
    end
    @(posedge clock); #1;
    drive(b, md, 1'b1);
    push_bit(b, md);
  endtask

  task automatic send_digit(input logic [3:0] d, input logic md);
    for (int j = 0; j < 4; j++) send(d[j], md, 0);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= 1'b0;
    else        acc_q <= bus_a.in_valid;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      check_val("out_valid", {bus_b.out_valid, bus_a.out_valid}, {2{acc_q}});
      if (bus_a.out_valid || bus_b.out_valid) begin
        if (bus_b.out_valid) ov_cnt_b++;
        if (bus_b.frame_last) fl_cnt_b++;
        if (sb.size() == 0) begin
          check_val("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("bit z=%b%b dl=%b%b fl=%b%b err=%b%b (b,a)", bus_b.z, bus_a.z,
                   bus_b.digit_last, bus_a.digit_last, bus_b.frame_last, bus_a.frame_last,
                   bus_b.err, bus_a.err);
          check_val("z",          {bus_b.z, bus_a.z}, e.z);
          check_val("digit_last", {bus_b.digit_last, bus_a.digit_last}, e.dl);
          check_val("frame_last", {bus_b.frame_last, bus_a.frame_last}, e.fl);
          check_val("err",        {bus_b.err, bus_a.err}, e.er);
        end
      end
    end
  end

  int gaps [3] = '{0, 1, 5};
  int ov0, fl0;
  logic [3:0] d37;

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    #1 reset = 1'b0;
    #2;
    check_val("rst_a", {bus_a.z, bus_a.out_valid, bus_a.digit_last, bus_a.frame_last, bus_a.err}, 0);
    check_val("rst_b", {bus_b.z, bus_b.out_valid, bus_b.digit_last, bus_b.frame_last, bus_b.err}, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    idle(2);

    // Contiguous digits: 5, 9, 0, 10 as BCD; then 12, 3, 1, 8 as XS3.
    send_digit(4'd5,  1'b0);
    send_digit(4'd9,  1'b0);
    send_digit(4'd0,  1'b0);
    send_digit(4'd10, 1'b0);
    send_digit(4'd12, 1'b1);
    send_digit(4'd3,  1'b1);
    send_digit(4'd1,  1'b1);
    send_digit(4'd8,  1'b1);
    idle(3);
    check_val("drain1", sb.size(), 0);

    // Digits 3 then 7 with stall gaps; mode toggled after the first bit.
    ov0 = ov_cnt_b;
    fl0 = fl_cnt_b;
    for (int j = 0; j < 8; j++) begin
      d37 = (j < 4) ? 4'd3 : 4'd7;
      send(d37[j % 4], (j == 0) ? 1'b0 : 1'b1, gaps[j % 3]);
    end
    idle(3);
    check_val("gap_ov_count", ov_cnt_b - ov0, 8);
    check_val("gap_fl_count", fl_cnt_b - fl0, 1);
    check_val("drain2", sb.size(), 0);

    // Reset after bit 2 of digit 1 of a frame.
    send_digit(4'd2, 1'b0);
    send(1'b1, 1'b0, 0);
    send(1'b0, 1'b0, 0);
    send(1'b1, 1'b0, 0);
    @(posedge clock); #2;
    check_val("pre_rst_ov", bus_b.out_valid, 1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check_val("async_rst_a", {bus_a.z, bus_a.out_valid, bus_a.digit_last, bus_a.frame_last, bus_a.err}, 0);
    check_val("async_rst_b", {bus_b.z, bus_b.out_valid, bus_b.digit_last, bus_b.frame_last, bus_b.err}, 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    send_digit(4'd4, 1'b0);
    send_digit(4'd4, 1'b0);
    idle(3);
    check_val("drain3", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule
